toeplitz_row_gen: RTL and testbench

//  Parametrised Toeplitz-matrix row generator for the privacy-amplification hash path.

---
 rtl/toeplitz_pkg.sv | 20 ++
 rtl/toeplitz_shift_reg.sv | 37 +++
 rtl/toeplitz_row_gen.sv | 96 +++++++++
 tb/tb_toeplitz_row_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/toeplitz_pkg.sv
// Shared types and defaults for the Toeplitz row generator.
// The index width helper keeps every user consistent when NUM_ROWS is tiny.
package toeplitz_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int unsigned DEF_ROW_W    = 3072;
  localparam int unsigned DEF_SHIFT_W  = 1;
  localparam int unsigned DEF_NUM_ROWS = 1024;

  // Width of row_idx; never zero, even for a single-row sequence.
  function automatic int unsigned idx_w(input int unsigned num_rows);
    return (num_rows <= 2) ? 1 : $clog2(num_rows);
  endfunction

endpackage

// File: rtl/toeplitz_shift_reg.sv
// Seed register with parallel load and SHIFT_W-bit serial shift.
// MODE selects shift direction and the end where fresh bits enter.
module toeplitz_shift_reg #(
  parameter int unsigned ROW_W   = 3072,
  parameter int unsigned SHIFT_W = 1,
  parameter bit          MODE    = 1'b0
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               load,
  input  logic               shift_en,
  input  logic [ROW_W-1:0]   load_data,
  input  logic [SHIFT_W-1:0] shift_in,
  output logic [ROW_W-1:0]   q
);

  logic [ROW_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_data;
    end else if (shift_en) begin
      if (MODE == 1'b0) q_d = {q_q[ROW_W-SHIFT_W-1:0], shift_in};
      else              q_d = {shift_in, q_q[ROW_W-1:SHIFT_W]};
    end
  end

  // NOTE: this wide datapath register is reset because row_data must read zero after reset.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/toeplitz_row_gen.sv
// Toeplitz row generator: emits the seed as row 0, then one row per fresh bit group.
// FSM, row counter and the three valid/ready handshakes live here.
module toeplitz_row_gen
  import toeplitz_pkg::*;
#(
  parameter int unsigned ROW_W    = DEF_ROW_W,
  parameter int unsigned SHIFT_W  = DEF_SHIFT_W,
  parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
  parameter bit          MODE     = 1'b0,
  localparam int unsigned IW      = idx_w(NUM_ROWS)
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               flush,
  input  logic               seed_valid,
  output logic               seed_ready,
  input  logic [ROW_W-1:0]   seed_data,
  input  logic               bit_valid,
  output logic               bit_ready,
  input  logic [SHIFT_W-1:0] bit_data,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [ROW_W-1:0]   row_data,
  output logic [IW-1:0]      row_idx,
  output logic               row_last,
  output logic               busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ROWS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            seed_fire, row_fire, bit_fire, is_last;

  // Handshakes are qualified internally by flush so the ready outputs stay state-decoded.
  assign seed_fire = (state_q == IDLE)  && seed_valid && !flush;
  assign row_fire  = (state_q == EMIT)  && row_ready  && !flush;
  assign bit_fire  = (state_q == SHIFT) && bit_valid  && !flush;
  assign is_last   = (cnt_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments only; next values come from always_comb.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (seed_fire) state_d = EMIT;
        EMIT:    if (row_fire)  state_d = is_last ? IDLE : SHIFT;
        SHIFT:   if (bit_fire)  state_d = EMIT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (seed_fire)     cnt_d = '0;
    else if (bit_fire) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    seed_ready = (state_q == IDLE);
    row_valid  = (state_q == EMIT);
    bit_ready  = (state_q == SHIFT);
    row_last   = (state_q == EMIT) && is_last;
    busy       = (state_q != IDLE);
    row_idx    = cnt_q;
  end

  toeplitz_shift_reg #(
    .ROW_W   (ROW_W),
    .SHIFT_W (SHIFT_W),
    .MODE    (MODE)
  ) u_shift_reg (
    .clk_in    (clk_in),
    .rst       (rst),
    .load      (seed_fire),
    .shift_en  (bit_fire),
    .load_data (seed_data),
    .shift_in  (bit_data),
    .q         (row_data)
  );

endmodule

// File: tb/tb_toeplitz_row_gen.sv
// Directed bench: table-driven cycle vectors on the main configuration plus
// hand-written sequences for MODE=1/SHIFT_W=2, NUM_ROWS=1 and async reset.
module tb_toeplitz_row_gen;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Instance A: ROW_W=8, SHIFT_W=1, NUM_ROWS=3, MODE=0
  logic       a_flush, a_seed_valid, a_seed_ready, a_bit_valid, a_bit_ready, a_bit_data;
  logic       a_row_valid, a_row_ready, a_row_last, a_busy;
  logic [7:0] a_seed_data, a_row_data;
  logic [1:0] a_row_idx;

  toeplitz_row_gen #(.ROW_W(8), .SHIFT_W(1), .NUM_ROWS(3), .MODE(1'b0)) dut_a (
    .clk_in(clk_in), .rst(rst), .flush(a_flush),
    .seed_valid(a_seed_valid), .seed_ready(a_seed_ready), .seed_data(a_seed_data),
    .bit_valid(a_bit_valid), .bit_ready(a_bit_ready), .bit_data(a_bit_data),
    .row_valid(a_row_valid), .row_ready(a_row_ready), .row_data(a_row_data),
    .row_idx(a_row_idx), .row_last(a_row_last), .busy(a_busy)
  );

  // Instance B: ROW_W=8, SHIFT_W=2, NUM_ROWS=3, MODE=1
  logic       b_seed_valid, b_seed_ready, b_bit_valid, b_bit_ready;
  logic       b_row_valid, b_row_ready, b_row_last, b_busy;
  logic [1:0] b_bit_data, b_row_idx;
  logic [7:0] b_seed_data, b_row_data;

  toeplitz_row_gen #(.ROW_W(8), .SHIFT_W(2), .NUM_ROWS(3), .MODE(1'b1)) dut_b (
    .clk_in(clk_in), .rst(rst), .flush(1'b0),
    .seed_valid(b_seed_valid), .seed_ready(b_seed_ready), .seed_data(b_seed_data),
    .bit_valid(b_bit_valid), .bit_ready(b_bit_ready), .bit_data(b_bit_data),
    .row_valid(b_row_valid), .row_ready(b_row_ready), .row_data(b_row_data),
    .row_idx(b_row_idx), .row_last(b_row_last), .busy(b_busy)
  );

  // Instance C: ROW_W=8, SHIFT_W=1, NUM_ROWS=1, MODE=0
  logic       c_seed_valid, c_seed_ready, c_bit_valid, c_bit_ready, c_bit_data;
  logic       c_row_valid, c_row_ready, c_row_last, c_busy;
  logic [0:0] c_row_idx;
  logic [7:0] c_seed_data, c_row_data;

  toeplitz_row_gen #(.ROW_W(8), .SHIFT_W(1), .NUM_ROWS(1), .MODE(1'b0)) dut_c (
    .clk_in(clk_in), .rst(rst), .flush(1'b0),
    .seed_valid(c_seed_valid), .seed_ready(c_seed_ready), .seed_data(c_seed_data),
    .bit_valid(c_bit_valid), .bit_ready(c_bit_ready), .bit_data(c_bit_data),
    .row_valid(c_row_valid), .row_ready(c_row_ready), .row_data(c_row_data),
    .row_idx(c_row_idx), .row_last(c_row_last), .busy(c_busy)
  );

  typedef struct {
    logic       sv;  logic [7:0] sd;
    logic       bv;  logic       bd;
    logic       rr;  logic       fl;
    logic       e_rv; logic [7:0] e_rd; logic [1:0] e_idx; logic e_last;
    logic       e_br; logic       e_sr; logic       e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic bv, input logic bd,
                              input logic rr, input logic fl, input logic e_rv, input logic [7:0] e_rd,
                              input logic [1:0] e_idx, input logic e_last, input logic e_br,
                              input logic e_sr, input logic e_busy);
    vec_t v;
    v.sv = sv; v.sd = sd; v.bv = bv; v.bd = bd; v.rr = rr; v.fl = fl;
    v.e_rv = e_rv; v.e_rd = e_rd; v.e_idx = e_idx; v.e_last = e_last;
    v.e_br = e_br; v.e_sr = e_sr; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Per-cycle vectors: inputs driven this cycle, expected outputs visible this cycle.
    // Basic run: seed A5, bits 1 then 0 -> A5, 4B, 96.
    vq.push_back(mk(1, 8'hA5, 0, 0, 0, 0,  0, 8'h00, 0, 0,  0, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 8'hA5, 0, 0,  0, 0, 1));
    vq.push_back(mk(0, 8'h00, 1, 1, 0, 0,  0, 8'h00, 0, 0,  1, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 8'h4B, 1, 0,  0, 0, 1));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0,  1, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 8'h96, 2, 1,  0, 0, 1));
    // Backpressure on row 1 with a bit on offer that must not be consumed.
    vq.push_back(mk(1, 8'hA5, 0, 0, 0, 0,  0, 8'h00, 0, 0,  0, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 8'hA5, 0, 0,  0, 0, 1));
    vq.push_back(mk(0, 8'h00, 1, 1, 0, 0,  0, 8'h00, 0, 0,  1, 0, 1));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 8'h00, 1, 1, 0, 0,  1, 8'h4B, 1, 0,  0, 0, 1));
    vq.push_back(mk(0, 8'h00, 1, 1, 1, 0,  1, 8'h4B, 1, 0,  0, 0, 1));
    vq.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0,  1, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 8'h96, 2, 1,  0, 0, 1));
    // Bit starvation in SHIFT, then flush on row 1 while row_ready=1.
    vq.push_back(mk(1, 8'hA5, 0, 0, 0, 0,  0, 8'h00, 0, 0,  0, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 8'hA5, 0, 0,  0, 0, 1));
    for (int i = 0; i < 10; i++)
      vq.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 8'h00, 0, 0,  1, 0, 1));
    vq.push_back(mk(0, 8'h00, 1, 1, 0, 0,  0, 8'h00, 0, 0,  1, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 1, 1,  1, 8'h4B, 1, 0,  0, 0, 1));
    vq.push_back(mk(1, 8'h5A, 0, 0, 0, 0,  0, 8'h00, 0, 0,  0, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 8'h5A, 0, 0,  0, 0, 1));
    // Flush out of EMIT with row_ready low; IDLE next cycle.
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 8'h5A, 0, 0,  0, 0, 1));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 8'h00, 0, 0,  0, 1, 0));

    rst = 1'b1;
    a_flush = 0; a_seed_valid = 0; a_seed_data = '0; a_bit_valid = 0; a_bit_data = 0; a_row_ready = 0;
    b_seed_valid = 0; b_seed_data = '0; b_bit_valid = 0; b_bit_data = '0; b_row_ready = 0;
    c_seed_valid = 0; c_seed_data = '0; c_bit_valid = 0; c_bit_data = 0; c_row_ready = 0;
    repeat (3) @(posedge clk_in);
    #1;

    // Reset values
    check("rst row_valid",  a_row_valid,  0);
    check("rst row_data",   a_row_data,   8'h00);
    check("rst row_idx",    a_row_idx,    0);
    check("rst row_last",   a_row_last,   0);
    check("rst bit_ready",  a_bit_ready,  0);
    check("rst busy",       a_busy,       0);
    check("rst seed_ready", a_seed_ready, 1);
    #4 rst = 1'b0;
    tick();

    foreach (vq[i]) begin
      a_seed_valid = vq[i].sv; a_seed_data = vq[i].sd;
      a_bit_valid  = vq[i].bv; a_bit_data  = vq[i].bd;
      a_row_ready  = vq[i].rr; a_flush     = vq[i].fl;
      check($sformatf("v%0d row_valid", i),  a_row_valid,  vq[i].e_rv);
      check($sformatf("v%0d bit_ready", i),  a_bit_ready,  vq[i].e_br);
      check($sformatf("v%0d seed_ready", i), a_seed_ready, vq[i].e_sr);
      check($sformatf("v%0d busy", i),       a_busy,       vq[i].e_busy);
      if (vq[i].e_rv) begin
        check($sformatf("v%0d row_data", i), a_row_data, vq[i].e_rd);
        check($sformatf("v%0d row_idx", i),  a_row_idx,  vq[i].e_idx);
      end
      check($sformatf("v%0d row_last", i), a_row_last, vq[i].e_last);
      tick();
    end
    a_seed_valid = 0; a_bit_valid = 0; a_row_ready = 0; a_flush = 0;

    // Async reset pulse while in SHIFT: outputs return before the next edge.
    a_seed_valid = 1; a_seed_data = 8'hF0;
    tick();
    a_seed_valid = 0; a_row_ready = 1;
    tick();
    a_row_ready = 0;
    check("pre-rst bit_ready", a_bit_ready, 1);
    #1 rst = 1'b1;
    #1;
    check("arst bit_ready",  a_bit_ready,  0);
    check("arst busy",       a_busy,       0);
    check("arst row_valid",  a_row_valid,  0);
    check("arst row_data",   a_row_data,   8'h00);
    check("arst row_idx",    a_row_idx,    0);
    check("arst seed_ready", a_seed_ready, 1);
    @(negedge clk_in);
    rst = 1'b0;
    tick();

    // SHIFT_W=2, MODE=1: seed A5, bits 11 -> row 1 = E9.
    b_seed_valid = 1; b_seed_data = 8'hA5;
    tick();
    b_seed_valid = 0;
    check("b row0 valid", b_row_valid, 1);
    check("b row0 data",  b_row_data,  8'hA5);
    b_row_ready = 1;
    tick();
    b_row_ready = 0;
    check("b shift bit_ready", b_bit_ready, 1);
    b_bit_valid = 1; b_bit_data = 2'b11;
    tick();
    b_bit_valid = 0;
    check("b row1 valid", b_row_valid, 1);
    check("b row1 data",  b_row_data,  8'hE9);
    check("b row1 idx",   b_row_idx,   1);

    // NUM_ROWS=1: seed only, row_last=1, bit_ready never asserted.
    c_seed_valid = 1; c_seed_data = 8'h3C; c_bit_valid = 1;
    tick();
    c_seed_valid = 0;
    check("c row valid", c_row_valid, 1);
    check("c row data",  c_row_data,  8'h3C);
    check("c row idx",   c_row_idx,   0);
    check("c row last",  c_row_last,  1);
    c_row_ready = 1;
    tick();
    c_row_ready = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("c idle%0d bit_ready", i),  c_bit_ready,  0);
      check($sformatf("c idle%0d seed_ready", i), c_seed_ready, 1);
      check($sformatf("c idle%0d row_valid", i),  c_row_valid,  0);
      tick();
    end
    c_bit_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
